// File: rtl/md_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : md_issue_ctrl
// Description : Issue/interlock control between the E stage and a multi-cycle
//               multiply/divide unit, with stall accounting and error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module md_issue_ctrl #(
    parameter int SAT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             e_valid,
    input  logic [3:0]       e_md_op,
    input  logic [31:0]      e_rs,
    input  logic [31:0]      e_rt,
    input  logic             d_md_use,
    input  logic             md_busy,
    input  logic [31:0]      md_hi,
    input  logic [31:0]      md_lo,
    output logic             md_start,
    output logic             md_op,
    output logic             md_sign,
    output logic             md_we,
    output logic             md_write_sel,
    output logic [31:0]      md_a,
    output logic [31:0]      md_b,
    output logic             stall,
    output logic [31:0]      e_md_result,
    output logic             proto_err,
    output logic [SAT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        BUSY = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             r_proto_err;
    logic             w_proto_set;
    logic [SAT_W-1:0] r_stall_cnt;
    logic             w_free;
    logic             w_is_arith;
    logic             w_is_move;
    logic             w_is_md;

    assign w_is_arith = (e_md_op >= 4'd1) && (e_md_op <= 4'd4);
    assign w_is_move  = (e_md_op == 4'd5) || (e_md_op == 4'd6);
    assign w_is_md    = (e_md_op >= 4'd1) && (e_md_op <= 4'd8);
    assign w_free     = (r_state == IDLE) && !md_busy;

    // Issue is suppressed while reset is held so the unit never sees a stray start.
    assign md_start     = !reset && e_valid && w_is_arith && w_free;
    assign md_we        = !reset && e_valid && w_is_move && w_free;
    assign md_op        = (e_md_op == 4'd3) || (e_md_op == 4'd4);
    assign md_sign      = (e_md_op == 4'd1) || (e_md_op == 4'd3);
    assign md_write_sel = (e_md_op == 4'd6);
    assign md_a         = e_rs;
    assign md_b         = e_rt;
    assign stall        = d_md_use && (md_start || (r_state != IDLE) || md_busy);

    always_comb begin
        e_md_result = 32'd0;
        if (e_md_op == 4'd7) begin
            e_md_result = md_hi;
        end else if (e_md_op == 4'd8) begin
            e_md_result = md_lo;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_proto_set  = 1'b0;
        case (r_state)
            IDLE: begin
                if (md_start) begin
                    w_next_state = ACK;
                end
                if (md_busy) begin
                    w_proto_set = 1'b1;
                end
            end
            ACK: begin
                if (md_busy) begin
                    w_next_state = BUSY;
                end else begin
                    w_next_state = IDLE;
                    w_proto_set  = 1'b1;
                end
            end
            BUSY: begin
                if (!md_busy) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
        // A request reaching E while the unit is unavailable means the interlock was bypassed.
        if (e_valid && w_is_md && !w_free) begin
            w_proto_set = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_proto_err <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_proto_set) begin
                r_proto_err <= 1'b1;
            end
            if (stall && (r_stall_cnt != {SAT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign proto_err = r_proto_err;
    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_md_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_md_issue_ctrl
// Description : Directed vector table plus multi-cycle sequences with a simple
//               multiply/divide unit model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_md_issue_ctrl;

    logic        clk;
    logic        reset;
    logic        e_valid;
    logic [3:0]  e_md_op;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic        d_md_use;
    logic        md_busy;
    logic [31:0] md_hi;
    logic [31:0] md_lo;

    logic        md_start, md_op, md_sign, md_we, md_write_sel, stall, proto_err;
    logic [31:0] md_a, md_b, e_md_result;
    logic [15:0] stall_cnt;

    logic        d2_md_start, d2_md_op, d2_md_sign, d2_md_we, d2_md_write_sel, d2_stall, d2_proto_err;
    logic [31:0] d2_md_a, d2_md_b, d2_e_md_result;
    logic [1:0]  d2_stall_cnt;

    md_issue_ctrl dut (
        .clk(clk), .reset(reset), .e_valid(e_valid), .e_md_op(e_md_op),
        .e_rs(e_rs), .e_rt(e_rt), .d_md_use(d_md_use), .md_busy(md_busy),
        .md_hi(md_hi), .md_lo(md_lo), .md_start(md_start), .md_op(md_op),
        .md_sign(md_sign), .md_we(md_we), .md_write_sel(md_write_sel),
        .md_a(md_a), .md_b(md_b), .stall(stall), .e_md_result(e_md_result),
        .proto_err(proto_err), .stall_cnt(stall_cnt)
    );

    md_issue_ctrl #(.SAT_W(2)) dut2 (
        .clk(clk), .reset(reset), .e_valid(e_valid), .e_md_op(e_md_op),
        .e_rs(e_rs), .e_rt(e_rt), .d_md_use(d_md_use), .md_busy(md_busy),
        .md_hi(md_hi), .md_lo(md_lo), .md_start(d2_md_start), .md_op(d2_md_op),
        .md_sign(d2_md_sign), .md_we(d2_md_we), .md_write_sel(d2_md_write_sel),
        .md_a(d2_md_a), .md_b(d2_md_b), .stall(d2_stall), .e_md_result(d2_e_md_result),
        .proto_err(d2_proto_err), .stall_cnt(d2_stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Unit model: busy for busy_len cycles after a start, results latched at start.
    int          busy_len = 0;
    logic [7:0]  unit_cnt = 8'd0;
    logic [31:0] unit_hi = 32'd0;
    logic [31:0] unit_lo = 32'd0;
    logic        tb_busy = 1'b0;
    logic        use_tb_hl = 1'b0;
    logic [31:0] tb_hi = 32'd0;
    logic [31:0] tb_lo = 32'd0;

    always @(posedge clk) begin
        if (reset) begin
            unit_cnt <= 8'd0;
        end else if (md_start) begin
            unit_cnt <= 8'(busy_len);
            if (md_op) begin
                unit_lo <= (md_b == 32'd0) ? 32'd0 : md_a / md_b;
                unit_hi <= (md_b == 32'd0) ? md_a : md_a % md_b;
            end else if (md_sign) begin
                {unit_hi, unit_lo} <= $signed({{32{md_a[31]}}, md_a}) * $signed({{32{md_b[31]}}, md_b});
            end else begin
                {unit_hi, unit_lo} <= {32'd0, md_a} * {32'd0, md_b};
            end
        end else if (unit_cnt != 8'd0) begin
            unit_cnt <= unit_cnt - 8'd1;
        end
    end

    assign md_busy = tb_busy | (unit_cnt != 8'd0);
    assign md_hi   = use_tb_hl ? tb_hi : unit_hi;
    assign md_lo   = use_tb_hl ? tb_lo : unit_lo;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        e_valid  = 1'b0;
        e_md_op  = 4'd0;
        d_md_use = 1'b0;
        tb_busy  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Walks the stall window with the dependent instruction waiting in D.
    task automatic wait_stall(output int nstall, output int nstart);
        nstall = 0;
        nstart = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            e_valid  = 1'b0;
            d_md_use = 1'b1;
            #1;
            if (md_start) nstart++;
            if (stall) nstall++;
            else break;
        end
    endtask

    typedef struct {
        logic       ev;
        logic [3:0] op;
        logic       du;
        logic       busy;
        logic       x_start;
        logic       x_we;
        logic       x_op;
        logic       x_sign;
        logic       x_wsel;
        logic       x_stall;
        logic [1:0] x_res;   // 0: zero, 1: HI, 2: LO
    } vec_t;

    vec_t vecs[13];
    int   nstall;
    int   nstart;
    logic [31:0] x_res;

    initial begin
        reset   = 1'b1;
        e_rs    = 32'd0;
        e_rt    = 32'd0;
        idle_inputs();
        repeat (2) @(negedge clk);
        #1;
        chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("reset_proto_err", 32'(proto_err), 32'd0);
        chk("reset_start", 32'(md_start), 32'd0);
        reset = 1'b0;

        //             ev    op    du    busy  start we    op    sign  wsel  stall res
        vecs[0]  = '{1'b1, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0};
        vecs[1]  = '{1'b1, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0};
        vecs[2]  = '{1'b1, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0};
        vecs[3]  = '{1'b1, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0};
        vecs[4]  = '{1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[5]  = '{1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
        vecs[6]  = '{1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1};
        vecs[7]  = '{1'b1, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2};
        vecs[8]  = '{1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0};
        vecs[9]  = '{1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[10] = '{1'b1, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[11] = '{1'b1, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[12] = '{1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0};

        // Combinational decode in IDLE; inputs are cleared before each edge so state never moves.
        use_tb_hl = 1'b1;
        tb_hi     = 32'hCAFE_0001;
        tb_lo     = 32'h1234_8765;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            e_valid  = vecs[i].ev;
            e_md_op  = vecs[i].op;
            d_md_use = vecs[i].du;
            tb_busy  = vecs[i].busy;
            e_rs     = 32'h1000_0000 + 32'(i);
            e_rt     = 32'hA5A5_0000 ^ 32'(i * 7);
            x_res    = (vecs[i].x_res == 2'd1) ? 32'hCAFE_0001 :
                       (vecs[i].x_res == 2'd2) ? 32'h1234_8765 : 32'd0;
            #1;
            chk($sformatf("v%0d_start", i), 32'(md_start), 32'(vecs[i].x_start));
            chk($sformatf("v%0d_we", i), 32'(md_we), 32'(vecs[i].x_we));
            chk($sformatf("v%0d_op", i), 32'(md_op), 32'(vecs[i].x_op));
            chk($sformatf("v%0d_sign", i), 32'(md_sign), 32'(vecs[i].x_sign));
            chk($sformatf("v%0d_wsel", i), 32'(md_write_sel), 32'(vecs[i].x_wsel));
            chk($sformatf("v%0d_stall", i), 32'(stall), 32'(vecs[i].x_stall));
            chk($sformatf("v%0d_result", i), e_md_result, x_res);
            chk($sformatf("v%0d_a", i), md_a, 32'h1000_0000 + 32'(i));
            chk($sformatf("v%0d_b", i), md_b, 32'hA5A5_0000 ^ 32'(i * 7));
            #1;
            idle_inputs();
        end
        use_tb_hl = 1'b0;
        @(negedge clk);
        chk("table_no_err", 32'(proto_err), 32'd0);
        chk("table_no_cnt", 32'(stall_cnt), 32'd0);

        // mult 3 * -2, unit busy 5 cycles, mfhi one slot behind
        do_reset();
        busy_len = 5;
        e_valid = 1'b1; e_md_op = 4'd1; e_rs = 32'd3; e_rt = 32'hFFFF_FFFE; d_md_use = 1'b0;
        #1;
        chk("mult_start", 32'(md_start), 32'd1);
        chk("mult_sign", 32'(md_sign), 32'd1);
        chk("mult_b", md_b, 32'hFFFF_FFFE);
        wait_stall(nstall, nstart);
        chk("mult_extra_start", 32'(nstart), 32'd0);
        chk("mult_stall_cycles", 32'(nstall), 32'd6);
        chk("mult_stall_cnt", 32'(stall_cnt), 32'd6);
        @(negedge clk);
        e_valid = 1'b1; e_md_op = 4'd7; d_md_use = 1'b0;
        #1;
        chk("mfhi_result", e_md_result, 32'hFFFF_FFFF);
        chk("mfhi_no_start", 32'(md_start), 32'd0);
        chk("mult_no_err", 32'(proto_err), 32'd0);

        // divu 7 / 2, busy 10 cycles, mflo queued
        do_reset();
        busy_len = 10;
        e_valid = 1'b1; e_md_op = 4'd4; e_rs = 32'd7; e_rt = 32'd2; d_md_use = 1'b0;
        #1;
        chk("divu_start", 32'(md_start), 32'd1);
        chk("divu_op", 32'(md_op), 32'd1);
        chk("divu_sign", 32'(md_sign), 32'd0);
        wait_stall(nstall, nstart);
        chk("divu_stall_cycles", 32'(nstall), 32'd11);
        chk("divu_stall_cnt", 32'(stall_cnt), 32'd11);
        @(negedge clk);
        e_valid = 1'b1; e_md_op = 4'd8; d_md_use = 1'b0;
        #1;
        chk("mflo_result", e_md_result, 32'd3);

        // mthi while idle: write-through, no stall
        @(negedge clk);
        e_valid = 1'b1; e_md_op = 4'd5; e_rs = 32'h0000_1234; d_md_use = 1'b1;
        #1;
        chk("mthi_we", 32'(md_we), 32'd1);
        chk("mthi_wsel", 32'(md_write_sel), 32'd0);
        chk("mthi_a", md_a, 32'h0000_1234);
        chk("mthi_stall", 32'(stall), 32'd0);
        @(negedge clk);
        idle_inputs();
        d_md_use = 1'b1;
        #1;
        chk("mthi_stays_idle", 32'(stall), 32'd0);

        // Unit never acknowledges: ACK falls back to IDLE and flags an error
        @(negedge clk);
        busy_len = 0;
        e_valid = 1'b1; e_md_op = 4'd2; e_rs = 32'd5; e_rt = 32'd6; d_md_use = 1'b0;
        #1;
        chk("noack_start", 32'(md_start), 32'd1);
        @(negedge clk);
        e_valid = 1'b0; d_md_use = 1'b1;
        #1;
        chk("noack_ack_stall", 32'(stall), 32'd1);
        chk("noack_err_pre", 32'(proto_err), 32'd0);
        @(negedge clk);
        #1;
        chk("noack_back_idle", 32'(stall), 32'd0);
        chk("noack_err", 32'(proto_err), 32'd1);
        repeat (3) @(negedge clk);
        #1;
        chk("noack_err_sticky", 32'(proto_err), 32'd1);

        // Reset in the middle of a divide clears state, error and counter
        @(negedge clk);
        busy_len = 10;
        e_valid = 1'b1; e_md_op = 4'd4; e_rs = 32'd7; e_rt = 32'd2; d_md_use = 1'b0;
        repeat (4) begin
            @(negedge clk);
            e_valid = 1'b0; d_md_use = 1'b1;
        end
        #1;
        chk("midbusy_stall", 32'(stall), 32'd1);
        e_valid = 1'b1; e_md_op = 4'd1; d_md_use = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_start_blocked", 32'(md_start), 32'd0);
        e_md_op = 4'd5;
        #1;
        chk("rst_we_blocked", 32'(md_we), 32'd0);
        e_md_op = 4'd7;
        #1;
        chk("rst_result_live", e_md_result, 32'd1);
        e_md_op = 4'd1;
        @(negedge clk);
        #1;
        chk("rst_err_clear", 32'(proto_err), 32'd0);
        chk("rst_cnt_clear", 32'(stall_cnt), 32'd0);
        chk("rst_hold_start", 32'(md_start), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        d_md_use = 1'b1;
        #1;
        chk("rst_state_idle", 32'(stall), 32'd0);

        // Saturation: five stall edges on a 2-bit counter
        do_reset();
        tb_busy  = 1'b1;
        d_md_use = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("sat_wide_cnt", 32'(stall_cnt), 32'd5);
        chk("sat_narrow_cnt", 32'(d2_stall_cnt), 32'd3);
        chk("idle_busy_err", 32'(proto_err), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
